// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the RV32 decode controller.
// Holds the opcode constants, the control-field enums, the registered
// control bundle struct and a helper that builds the bubble bundle.
package ctrl_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // funct7 classes for register-register ops
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // SYSTEM immediates for the privileged instructions
  localparam logic [11:0] IMM_MRET  = 12'h302;
  localparam logic [11:0] IMM_ECALL = 12'h000;

  // Mul/div cycle counter
  localparam int MD_CNT_W = 16;
  localparam logic [MD_CNT_W-1:0] MD_CNT_ZERO = {MD_CNT_W{1'b0}};
  localparam logic [MD_CNT_W-1:0] MD_CNT_ONE  = {{(MD_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [4:0] {
    ALU_ADD    = 5'h00, ALU_SUB  = 5'h01, ALU_SLL    = 5'h02, ALU_SLT   = 5'h03,
    ALU_SLTU   = 5'h04, ALU_XOR  = 5'h05, ALU_SRL    = 5'h06, ALU_SRA   = 5'h07,
    ALU_OR     = 5'h08, ALU_AND  = 5'h09, ALU_PASS_B = 5'h0A, ALU_MUL   = 5'h0B,
    ALU_MULH   = 5'h0C, ALU_MULHSU = 5'h0D, ALU_MULHU = 5'h0E, ALU_DIV  = 5'h0F,
    ALU_DIVU   = 5'h10, ALU_REM  = 5'h11, ALU_REMU   = 5'h12
  } aluop_e;

  // BR_NONE/BR_JUMP sit above the branch codes so the six conditions stay distinct
  typedef enum logic [2:0] {
    BR_EQ = 3'b000, BR_NE = 3'b001, BR_LT = 3'b010, BR_GE = 3'b011,
    BR_LTU = 3'b100, BR_GEU = 3'b101, BR_NONE = 3'b110, BR_JUMP = 3'b111
  } br_type_e;

  // Encoded identically to the load/store funct3 field
  typedef enum logic [2:0] {
    MEM_B = 3'b000, MEM_H = 3'b001, MEM_W = 3'b010, MEM_BU = 3'b100, MEM_HU = 3'b101
  } mem_type_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10, WB_CSR = 2'b11
  } sel_wb_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011,
    IMM_J = 3'b100, IMM_Z = 3'b101
  } imm_type_e;

  // Matches funct3[1:0] of the CSR instructions
  typedef enum logic [1:0] {
    CSR_NONE = 2'b00, CSR_WRITE = 2'b01, CSR_SET = 2'b10, CSR_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic {
    ST_RUN = 1'b0, ST_MD_WAIT = 1'b1
  } pipe_state_e;

  typedef struct packed {
    logic      rf_en;
    logic      rd_en;
    logic      wr_en;
    logic      sel_opr_a;
    logic      sel_opr_b;
    aluop_e    aluop;
    br_type_e  br_type;
    mem_type_e mem_type;
    sel_wb_e   sel_wb;
    imm_type_e imm_type;
    logic      csr_rd;
    logic      csr_wr;
    csr_op_e   csr_op;
    logic      is_mret;
    logic      is_ecall;
    logic      illegal;
  } ctrl_bundle_t;

  // Bundle with every enable off and no branch: used for bubbles, reset and illegal
  function automatic ctrl_bundle_t bubble_bundle();
    ctrl_bundle_t b;
    b.rf_en     = 1'b0;
    b.rd_en     = 1'b0;
    b.wr_en     = 1'b0;
    b.sel_opr_a = 1'b0;
    b.sel_opr_b = 1'b0;
    b.aluop     = ALU_ADD;
    b.br_type   = BR_NONE;
    b.mem_type  = MEM_B;
    b.sel_wb    = WB_ALU;
    b.imm_type  = IMM_I;
    b.csr_rd    = 1'b0;
    b.csr_wr    = 1'b0;
    b.csr_op    = CSR_NONE;
    b.is_mret   = 1'b0;
    b.is_ecall  = 1'b0;
    b.illegal   = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// rv_ctrl_decode: purely combinational RV32I/Zicsr/RV32M instruction decoder.
// Ports:
//   instr_i     - 32-bit instruction
//   ctrl_o      - decoded control bundle (illegal encodings give the bubble
//                 bundle with illegal=1)
//   is_md_o     - instruction is a legal RV32M op
//   md_cycles_o - execute cycles the M op occupies (0 when not an M op)
module rv_ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MUL_CYCLES = 1,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic [31:0]         instr_i,
  output ctrl_bundle_t        ctrl_o,
  output logic                is_md_o,
  output logic [MD_CNT_W-1:0] md_cycles_o
);

  logic [6:0]          opcode_s;
  logic [2:0]          funct3_s;
  logic [6:0]          funct7_s;
  logic [4:0]          rd_s;
  logic [4:0]          rs1_s;
  logic [11:0]         imm12_s;
  ctrl_bundle_t        dec_s;
  logic                illegal_s;
  logic                is_md_s;
  logic [MD_CNT_W-1:0] md_cycles_s;

  assign opcode_s = instr_i[6:0];
  assign rd_s     = instr_i[11:7];
  assign funct3_s = instr_i[14:12];
  assign rs1_s    = instr_i[19:15];
  assign funct7_s = instr_i[31:25];
  assign imm12_s  = instr_i[31:20];

  // Base ALU op selected by funct3 (ADD/SRL variants; SUB/SRA handled by caller)
  function automatic aluop_e base_aluop(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  // RV32M op selected by funct3
  function automatic aluop_e md_aluop(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      3'b111:  return ALU_REMU;
      default: return ALU_MUL;
    endcase
  endfunction

  // Field decode per opcode; flags any undefined encoding
  always_comb begin
    dec_s       = bubble_bundle();
    illegal_s   = 1'b0;
    is_md_s     = 1'b0;
    md_cycles_s = MD_CNT_ZERO;
    case (opcode_s)
      OPC_OP: begin
        dec_s.rf_en = 1'b1;
        case (funct7_s)
          F7_BASE: dec_s.aluop = base_aluop(funct3_s);
          F7_ALT: begin
            case (funct3_s)
              3'b000:  dec_s.aluop = ALU_SUB;
              3'b101:  dec_s.aluop = ALU_SRA;
              default: illegal_s = 1'b1;
            endcase
          end
          F7_MULDIV: begin
            if (ENABLE_M) begin
              dec_s.aluop = md_aluop(funct3_s);
              is_md_s     = 1'b1;
              // funct3[2] splits MUL* from DIV/REM*
              md_cycles_s = funct3_s[2] ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MUL_CYCLES);
            end else begin
              illegal_s = 1'b1;
            end
          end
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_s.rf_en     = 1'b1;
        dec_s.sel_opr_b = 1'b1;
        dec_s.imm_type  = IMM_I;
        case (funct3_s)
          3'b001: begin
            if (funct7_s == F7_BASE) begin
              dec_s.aluop = ALU_SLL;
            end else begin
              illegal_s = 1'b1;
            end
          end
          3'b101: begin
            if (funct7_s == F7_BASE) begin
              dec_s.aluop = ALU_SRL;
            end else if (funct7_s == F7_ALT) begin
              dec_s.aluop = ALU_SRA;
            end else begin
              illegal_s = 1'b1;
            end
          end
          default: dec_s.aluop = base_aluop(funct3_s);
        endcase
      end
      OPC_LOAD: begin
        case (funct3_s)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
            dec_s.rf_en     = 1'b1;
            dec_s.rd_en     = 1'b1;
            dec_s.sel_opr_b = 1'b1;
            dec_s.imm_type  = IMM_I;
            dec_s.sel_wb    = WB_MEM;
            dec_s.mem_type  = mem_type_e'(funct3_s);
          end
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_STORE: begin
        case (funct3_s)
          3'b000, 3'b001, 3'b010: begin
            dec_s.wr_en     = 1'b1;
            dec_s.sel_opr_b = 1'b1;
            dec_s.imm_type  = IMM_S;
            dec_s.mem_type  = mem_type_e'(funct3_s);
          end
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        // Operand A is the PC so the ALU forms the branch target
        dec_s.sel_opr_a = 1'b1;
        dec_s.sel_opr_b = 1'b1;
        dec_s.imm_type  = IMM_B;
        case (funct3_s)
          3'b000:  dec_s.br_type = BR_EQ;
          3'b001:  dec_s.br_type = BR_NE;
          3'b100:  dec_s.br_type = BR_LT;
          3'b101:  dec_s.br_type = BR_GE;
          3'b110:  dec_s.br_type = BR_LTU;
          3'b111:  dec_s.br_type = BR_GEU;
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec_s.rf_en     = 1'b1;
        dec_s.sel_opr_a = 1'b1;
        dec_s.sel_opr_b = 1'b1;
        dec_s.imm_type  = IMM_J;
        dec_s.br_type   = BR_JUMP;
        dec_s.sel_wb    = WB_PC4;
      end
      OPC_JALR: begin
        if (funct3_s == 3'b000) begin
          dec_s.rf_en     = 1'b1;
          dec_s.sel_opr_b = 1'b1;
          dec_s.imm_type  = IMM_I;
          dec_s.br_type   = BR_JUMP;
          dec_s.sel_wb    = WB_PC4;
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_s.rf_en     = 1'b1;
        dec_s.sel_opr_b = 1'b1;
        dec_s.imm_type  = IMM_U;
        dec_s.aluop     = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        dec_s.rf_en     = 1'b1;
        dec_s.sel_opr_a = 1'b1;
        dec_s.sel_opr_b = 1'b1;
        dec_s.imm_type  = IMM_U;
      end
      OPC_MISC_MEM: begin
        // FENCE: no ordering hazards exist in this in-order core, decode as a no-op
        dec_s.br_type = BR_NONE;
      end
      OPC_SYSTEM: begin
        case (funct3_s)
          3'b000: begin
            if (imm12_s == IMM_MRET) begin
              dec_s.is_mret = 1'b1;
            end else if (imm12_s == IMM_ECALL) begin
              dec_s.is_ecall = 1'b1;
            end else begin
              illegal_s = 1'b1;
            end
          end
          3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111: begin
            dec_s.rf_en     = 1'b1;
            dec_s.sel_wb    = WB_CSR;
            dec_s.csr_op    = csr_op_e'(funct3_s[1:0]);
            dec_s.sel_opr_a = funct3_s[2];
            dec_s.imm_type  = funct3_s[2] ? IMM_Z : IMM_I;
            dec_s.csr_rd    = (rd_s != 5'd0);
            // Set/clear with a zero mask must not write (no side effects)
            dec_s.csr_wr    = (funct3_s[1:0] == 2'b01) || (rs1_s != 5'd0);
          end
          default: illegal_s = 1'b1;
        endcase
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Illegal encodings collapse to the bubble bundle with only illegal set
  always_comb begin
    if (illegal_s) begin
      ctrl_o         = bubble_bundle();
      ctrl_o.illegal = 1'b1;
      is_md_o        = 1'b0;
      md_cycles_o    = MD_CNT_ZERO;
    end else begin
      ctrl_o         = dec_s;
      is_md_o        = is_md_s;
      md_cycles_o    = md_cycles_s;
    end
  end

endmodule

// File: rtl/rv_ctrl_pipe.sv
// rv_ctrl_pipe: registers the decoded control bundle into execute and owns
// stall/flush sequencing, including the multi-cycle mul/div wait FSM.
// Ports:
//   clk, rst_n (synchronous, active low)
//   instr_i, instr_valid_i     - instruction from the decode register
//   stall_i                    - downstream hold, freezes all state
//   flush_i                    - kills the held bundle, returns FSM to RUN
//   stall_o                    - hold PC/decode register while a M op runs
//   ctrl_valid_o               - execute bundle is live
//   rf_en_o .. illegal_o       - registered control bundle fields
//   md_start_o                 - one-cycle start pulse to the mul/div unit
module rv_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MUL_CYCLES = 1,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        ctrl_valid_o,
  output logic        rf_en_o,
  output logic        rd_en_o,
  output logic        wr_en_o,
  output logic        sel_opr_a_o,
  output logic        sel_opr_b_o,
  output logic [4:0]  aluop_o,
  output logic [2:0]  br_type_o,
  output logic [2:0]  mem_type_o,
  output logic [1:0]  sel_wb_o,
  output logic [2:0]  imm_type_o,
  output logic        csr_rd_o,
  output logic        csr_wr_o,
  output logic [1:0]  csr_op_o,
  output logic        is_mret_o,
  output logic        is_ecall_o,
  output logic        illegal_o,
  output logic        md_start_o
);

  ctrl_bundle_t        dec_bundle_s;
  logic                dec_is_md_s;
  logic [MD_CNT_W-1:0] dec_cycles_s;

  pipe_state_e         state_r,    state_nxt_s;
  logic [MD_CNT_W-1:0] cnt_r,      cnt_nxt_s;
  ctrl_bundle_t        bundle_r,   bundle_nxt_s;
  logic                valid_r,    valid_nxt_s;
  logic                md_start_r, md_start_nxt_s;

  logic                busy_s;
  logic                accept_s;

  rv_ctrl_decode #(
    .ENABLE_M   (ENABLE_M),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_decode (
    .instr_i     (instr_i),
    .ctrl_o      (dec_bundle_s),
    .is_md_o     (dec_is_md_s),
    .md_cycles_o (dec_cycles_s)
  );

  // Busy covers every MD_WAIT cycle but the last, so it depends only on state/cnt
  assign busy_s   = (state_r == ST_MD_WAIT) && (cnt_r != MD_CNT_ZERO);
  assign accept_s = instr_valid_i & ~busy_s & ~stall_i;

  // Next-state logic: flush beats stall, stall beats everything else
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    bundle_nxt_s   = bundle_r;
    valid_nxt_s    = valid_r;
    md_start_nxt_s = md_start_r;
    if (flush_i) begin
      state_nxt_s    = ST_RUN;
      cnt_nxt_s      = MD_CNT_ZERO;
      bundle_nxt_s   = bubble_bundle();
      valid_nxt_s    = 1'b0;
      md_start_nxt_s = 1'b0;
    end else if (stall_i) begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
    end else if (busy_s) begin
      // M op still running: keep its bundle, count down, start pulse is over
      cnt_nxt_s      = cnt_r - MD_CNT_ONE;
      md_start_nxt_s = 1'b0;
    end else begin
      md_start_nxt_s = accept_s & dec_is_md_s;
      if (accept_s) begin
        bundle_nxt_s = dec_bundle_s;
        valid_nxt_s  = 1'b1;
        if (dec_is_md_s && (dec_cycles_s > MD_CNT_ONE)) begin
          state_nxt_s = ST_MD_WAIT;
          cnt_nxt_s   = dec_cycles_s - MD_CNT_ONE;
        end else begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = MD_CNT_ZERO;
        end
      end else begin
        bundle_nxt_s = bubble_bundle();
        valid_nxt_s  = 1'b0;
        state_nxt_s  = ST_RUN;
        cnt_nxt_s    = MD_CNT_ZERO;
      end
    end
  end

  // State, counter and execute bundle registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      cnt_r      <= MD_CNT_ZERO;
      bundle_r   <= bubble_bundle();
      valid_r    <= 1'b0;
      md_start_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      bundle_r   <= bundle_nxt_s;
      valid_r    <= valid_nxt_s;
      md_start_r <= md_start_nxt_s;
    end
  end

  assign stall_o      = busy_s;
  assign ctrl_valid_o = valid_r;
  // Writeback only in the last M-op cycle, and a flush in that cycle cancels it
  assign rf_en_o      = bundle_r.rf_en & ~busy_s & ~((state_r == ST_MD_WAIT) & flush_i);
  assign rd_en_o      = bundle_r.rd_en;
  assign wr_en_o      = bundle_r.wr_en;
  assign sel_opr_a_o  = bundle_r.sel_opr_a;
  assign sel_opr_b_o  = bundle_r.sel_opr_b;
  assign aluop_o      = bundle_r.aluop;
  assign br_type_o    = bundle_r.br_type;
  assign mem_type_o   = bundle_r.mem_type;
  assign sel_wb_o     = bundle_r.sel_wb;
  assign imm_type_o   = bundle_r.imm_type;
  assign csr_rd_o     = bundle_r.csr_rd;
  assign csr_wr_o     = bundle_r.csr_wr;
  assign csr_op_o     = bundle_r.csr_op;
  assign is_mret_o    = bundle_r.is_mret;
  assign is_ecall_o   = bundle_r.is_ecall;
  assign illegal_o    = bundle_r.illegal;
  assign md_start_o   = md_start_r;

endmodule

// File: tb/tb_rv_ctrl_pipe.sv
// Directed bench for rv_ctrl_pipe. One instance has RV32M enabled with a
// 4-cycle divide and 1-cycle multiply; a second instance has RV32M disabled.
module tb_rv_ctrl_pipe;

  localparam logic [31:0] I_ADD    = 32'h00B50533;
  localparam logic [31:0] I_DIV    = 32'h02B54533;
  localparam logic [31:0] I_MUL    = 32'h02B50533;
  localparam logic [31:0] I_ADDI   = 32'h00500093;
  localparam logic [31:0] I_BAD    = 32'h0000007F;
  localparam logic [31:0] I_CSRRS  = 32'h300022F3;
  localparam logic [31:0] I_CSRRW  = 32'h30031073;
  localparam logic [31:0] I_MRET   = 32'h30200073;
  localparam logic [31:0] I_ECALL  = 32'h00000073;
  localparam logic [31:0] I_JAL    = 32'h000000EF;
  localparam logic [31:0] I_BEQ    = 32'h00000063;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall_in;
  logic        flush;

  logic       stall_o, ctrl_valid, rf_en, rd_en, wr_en, sel_a, sel_b;
  logic [4:0] aluop;
  logic [2:0] br_type, mem_type, imm_type;
  logic [1:0] sel_wb, csr_op;
  logic       csr_rd, csr_wr, is_mret, is_ecall, illegal, md_start;

  logic       n_stall_o, n_ctrl_valid, n_rf_en, n_rd_en, n_wr_en, n_sel_a, n_sel_b;
  logic [4:0] n_aluop;
  logic [2:0] n_br_type, n_mem_type, n_imm_type;
  logic [1:0] n_sel_wb, n_csr_op;
  logic       n_csr_rd, n_csr_wr, n_is_mret, n_is_ecall, n_illegal, n_md_start;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rv_ctrl_pipe #(.ENABLE_M(1'b1), .MUL_CYCLES(1), .DIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(instr_valid),
    .stall_i(stall_in), .flush_i(flush), .stall_o(stall_o), .ctrl_valid_o(ctrl_valid),
    .rf_en_o(rf_en), .rd_en_o(rd_en), .wr_en_o(wr_en), .sel_opr_a_o(sel_a),
    .sel_opr_b_o(sel_b), .aluop_o(aluop), .br_type_o(br_type), .mem_type_o(mem_type),
    .sel_wb_o(sel_wb), .imm_type_o(imm_type), .csr_rd_o(csr_rd), .csr_wr_o(csr_wr),
    .csr_op_o(csr_op), .is_mret_o(is_mret), .is_ecall_o(is_ecall),
    .illegal_o(illegal), .md_start_o(md_start)
  );

  rv_ctrl_pipe #(.ENABLE_M(1'b0), .MUL_CYCLES(1), .DIV_CYCLES(4)) dut_nom (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(instr_valid),
    .stall_i(stall_in), .flush_i(flush), .stall_o(n_stall_o), .ctrl_valid_o(n_ctrl_valid),
    .rf_en_o(n_rf_en), .rd_en_o(n_rd_en), .wr_en_o(n_wr_en), .sel_opr_a_o(n_sel_a),
    .sel_opr_b_o(n_sel_b), .aluop_o(n_aluop), .br_type_o(n_br_type), .mem_type_o(n_mem_type),
    .sel_wb_o(n_sel_wb), .imm_type_o(n_imm_type), .csr_rd_o(n_csr_rd), .csr_wr_o(n_csr_wr),
    .csr_op_o(n_csr_op), .is_mret_o(n_is_mret), .is_ecall_o(n_is_ecall),
    .illegal_o(n_illegal), .md_start_o(n_md_start)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'h0000_0000; instr_valid = 1'b0;
    stall_in = 1'b0; flush = 1'b0;
    tick(); tick();
    check("rst_valid",    {31'd0, ctrl_valid}, 32'd0);
    check("rst_rf_en",    {31'd0, rf_en},      32'd0);
    check("rst_br_type",  {29'd0, br_type},    32'd6);
    check("rst_stall",    {31'd0, stall_o},    32'd0);
    check("rst_md_start", {31'd0, md_start},   32'd0);
    check("rst_illegal",  {31'd0, illegal},    32'd0);
    rst_n = 1'b1;

    // ADD: one-cycle decode latency
    instr = I_ADD; instr_valid = 1'b1;
    tick();
    check("add_valid",  {31'd0, ctrl_valid}, 32'd1);
    check("add_rf_en",  {31'd0, rf_en},      32'd1);
    check("add_aluop",  {27'd0, aluop},      32'h00);
    check("add_sel_wb", {30'd0, sel_wb},     32'd0);
    check("add_stall",  {31'd0, stall_o},    32'd0);

    // DIV (4 cycles) followed by ADDI waiting in decode
    instr = I_DIV;
    tick();
    check("div_c1_md_start", {31'd0, md_start},  32'd1);
    check("div_c1_stall",    {31'd0, stall_o},   32'd1);
    check("div_c1_rf_en",    {31'd0, rf_en},     32'd0);
    check("div_c1_aluop",    {27'd0, aluop},     32'h0F);
    check("nom_div_illegal", {31'd0, n_illegal}, 32'd1);
    check("nom_div_rf_en",   {31'd0, n_rf_en},   32'd0);
    instr = I_ADDI;
    tick();
    check("div_c2_md_start", {31'd0, md_start}, 32'd0);
    check("div_c2_stall",    {31'd0, stall_o},  32'd1);
    check("div_c2_rf_en",    {31'd0, rf_en},    32'd0);
    tick();
    check("div_c3_stall",    {31'd0, stall_o},  32'd1);
    check("div_c3_rf_en",    {31'd0, rf_en},    32'd0);
    tick();
    check("div_c4_stall",    {31'd0, stall_o},  32'd0);
    check("div_c4_rf_en",    {31'd0, rf_en},    32'd1);
    check("div_c4_aluop",    {27'd0, aluop},    32'h0F);
    tick();
    check("div_c5_next_aluop", {27'd0, aluop},    32'h00);
    check("div_c5_next_selb",  {31'd0, sel_b},    32'd1);
    check("div_c5_next_rf_en", {31'd0, rf_en},    32'd1);
    instr_valid = 1'b0;
    tick();
    check("bubble_valid", {31'd0, ctrl_valid}, 32'd0);
    check("bubble_br",    {29'd0, br_type},    32'd6);

    // DIV flushed in its second cycle
    instr = I_DIV; instr_valid = 1'b1;
    tick();
    check("dfl_c1_md_start", {31'd0, md_start}, 32'd1);
    instr_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check("dfl_c2_rf_en", {31'd0, rf_en}, 32'd0);
    tick();
    flush = 1'b0;
    check("dfl_c3_valid",    {31'd0, ctrl_valid}, 32'd0);
    check("dfl_c3_stall",    {31'd0, stall_o},    32'd0);
    check("dfl_c3_rf_en",    {31'd0, rf_en},      32'd0);
    check("dfl_c3_md_start", {31'd0, md_start},   32'd0);
    instr = I_ADD; instr_valid = 1'b1;
    tick();
    check("dfl_run_accept", {31'd0, ctrl_valid}, 32'd1);
    check("dfl_run_aluop",  {27'd0, aluop},      32'h00);

    // DIV flushed in its last cycle: writeback cancelled
    instr = I_DIV;
    tick();
    instr_valid = 1'b0;
    tick(); tick(); tick();
    check("dlast_rf_en_pre", {31'd0, rf_en}, 32'd1);
    flush = 1'b1;
    #1;
    check("dlast_rf_en_flush", {31'd0, rf_en}, 32'd0);
    tick();
    flush = 1'b0;
    check("dlast_bubble", {31'd0, ctrl_valid}, 32'd0);

    // MUL with a 1-cycle latency never stalls
    instr = I_MUL; instr_valid = 1'b1;
    tick();
    check("mul_md_start",    {31'd0, md_start},  32'd1);
    check("mul_stall",       {31'd0, stall_o},   32'd0);
    check("mul_rf_en",       {31'd0, rf_en},     32'd1);
    check("mul_aluop",       {27'd0, aluop},     32'h0B);
    check("nom_mul_illegal", {31'd0, n_illegal}, 32'd1);
    check("nom_mul_rf_en",   {31'd0, n_rf_en},   32'd0);
    check("nom_mul_br",      {29'd0, n_br_type}, 32'd6);
    instr_valid = 1'b0;
    tick();
    check("mul_pulse_end", {31'd0, md_start}, 32'd0);

    // Unknown opcode
    instr = I_BAD; instr_valid = 1'b1;
    tick();
    check("bad_illegal", {31'd0, illegal},    32'd1);
    check("bad_rf_en",   {31'd0, rf_en},      32'd0);
    check("bad_wr_en",   {31'd0, wr_en},      32'd0);
    check("bad_br",      {29'd0, br_type},    32'd6);
    check("bad_valid",   {31'd0, ctrl_valid}, 32'd1);

    // CSR, privileged and control-flow decode
    instr = I_CSRRS;
    tick();
    check("csrrs_rd",     {31'd0, csr_rd},  32'd1);
    check("csrrs_wr",     {31'd0, csr_wr},  32'd0);
    check("csrrs_op",     {30'd0, csr_op},  32'd2);
    check("csrrs_sel_wb", {30'd0, sel_wb},  32'd3);
    instr = I_CSRRW;
    tick();
    check("csrrw_rd", {31'd0, csr_rd}, 32'd0);
    check("csrrw_wr", {31'd0, csr_wr}, 32'd1);
    check("csrrw_op", {30'd0, csr_op}, 32'd1);
    instr = I_MRET;
    tick();
    check("mret_flag",    {31'd0, is_mret}, 32'd1);
    check("mret_illegal", {31'd0, illegal}, 32'd0);
    instr = I_ECALL;
    tick();
    check("ecall_flag", {31'd0, is_ecall}, 32'd1);
    check("ecall_mret", {31'd0, is_mret},  32'd0);
    instr = I_JAL;
    tick();
    check("jal_br",     {29'd0, br_type}, 32'd7);
    check("jal_sel_wb", {30'd0, sel_wb},  32'd2);
    check("jal_rf_en",  {31'd0, rf_en},   32'd1);
    instr = I_BEQ;
    tick();
    check("beq_br",    {29'd0, br_type}, 32'd0);
    check("beq_rf_en", {31'd0, rf_en},   32'd0);

    // DIV with stall_i held for 3 cycles: completion moves from cycle 4 to 7
    instr = I_DIV;
    tick();
    instr_valid = 1'b0;
    tick();
    stall_in = 1'b1;
    tick();
    check("dst_frozen_stall", {31'd0, stall_o}, 32'd1);
    tick(); tick();
    stall_in = 1'b0;
    #1;
    check("dst_c5_stall",    {31'd0, stall_o},  32'd1);
    check("dst_c5_md_start", {31'd0, md_start}, 32'd0);
    tick();
    check("dst_c6_stall", {31'd0, stall_o}, 32'd1);
    check("dst_c6_rf_en", {31'd0, rf_en},   32'd0);
    tick();
    check("dst_c7_stall", {31'd0, stall_o}, 32'd0);
    check("dst_c7_rf_en", {31'd0, rf_en},   32'd1);
    tick();
    check("dst_done_valid", {31'd0, ctrl_valid}, 32'd0);

    // Reset in the middle of a DIV
    instr = I_DIV; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("rdiv_valid",    {31'd0, ctrl_valid}, 32'd0);
    check("rdiv_stall",    {31'd0, stall_o},    32'd0);
    check("rdiv_rf_en",    {31'd0, rf_en},      32'd0);
    check("rdiv_md_start", {31'd0, md_start},   32'd0);
    check("rdiv_aluop",    {27'd0, aluop},      32'h00);
    check("rdiv_br",       {29'd0, br_type},    32'd6);
    rst_n = 1'b1;
    instr = I_ADD; instr_valid = 1'b1;
    tick();
    check("rdiv_run_accept", {31'd0, ctrl_valid}, 32'd1);
    check("rdiv_run_stall",  {31'd0, stall_o},    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rv_ctrl_pipe.md
# rv_ctrl_pipe

Pipelined, parametrised decode controller for the RV32 core. It decodes RV32I, Zicsr, mret/ecall and optionally RV32M, and flags illegal encodings; every output is fully defined for every input. It registers the control bundle into the execute stage and owns stall/flush sequencing, including a multi-cycle divide FSM that stalls fetch/decode. It sits between the fetch/decode register and the execute stage.

## Interface
- `ENABLE_M`, 1: decode RV32M; when 0, any M encoding raises illegal.
- `MUL_CYCLES`, 1: execute cycles for MUL/MULH/MULHSU/MULHU (≥1).
- `DIV_CYCLES`, 33: execute cycles for DIV/DIVU/REM/REMU (≥1).
- `clk` in 1: clock; the block uses a single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `instr_i` in 32: instruction from the decode register.
- `instr_valid_i` in 1: `instr_i` holds a real instruction.
- `stall_i` in 1: downstream hold (memory); freezes all state.
- `flush_i` in 1: branch taken or trap; kills the held bundle.
- `stall_o` out 1: hold PC and the decode register.
- `ctrl_valid_o` out 1: the execute bundle is live.
- `rf_en_o`, `rd_en_o`, `wr_en_o`, `sel_opr_a_o`, `sel_opr_b_o` out 1 each.
- `aluop_o` out 5, `br_type_o` out 3, `mem_type_o` out 3, `sel_wb_o` out 2, `imm_type_o` out 3.
- `csr_rd_o`, `csr_wr_o` out 1 each; `csr_op_o` out 2 (01 write, 10 set, 11 clear).
- `is_mret_o`, `is_ecall_o`, `illegal_o` out 1 each.
- `md_start_o` out 1: one-cycle start pulse to the mul/div unit.

## Operation
- **Decode map.**
  - RV32I encodings keep the existing aluop codes: 0x00 ADD through 0x09 AND, 0x0A pass-B.
  - M-extension aluop codes: 0x0B MUL, 0x0C MULH, 0x0D MULHSU, 0x0E MULHU, 0x0F DIV, 0x10 DIVU, 0x11 REM, 0x12 REMU.
  - br_type: 110 none, 111 jump.
- **Defaults.** Every output has a default (all enables 0, br_type 110), so no latches are inferred.
- **Illegal.** Unknown opcode, or funct3/funct7 combinations that are not defined, produce `illegal_o`=1 with all enables 0 and br_type 110.
- **CSR.** funct3 001/010/011 use the register source; 101/110/111 use the zimm source (`sel_opr_a_o`=1).
  - `csr_rd_o`=1 whenever rd≠0.
  - `csr_wr_o`=1 unless the op is set/clear with rs1/zimm=0.
  - funct3 000 with imm 0x302 sets `is_mret_o`; imm 0x000 sets `is_ecall_o`; any other imm is illegal.
- **Accept.** An instruction is accepted when `instr_valid_i & ~stall_o & ~stall_i`. The decoded bundle is registered with `ctrl_valid_o`=1.
- **Bubble.** When `instr_valid_i`=0 and there is no stall, the registered bundle is a bubble (`ctrl_valid_o`=0, all enables 0).
- **FSM states:** RUN, MD_WAIT.
  - RUN → MD_WAIT when an M op is accepted and its cycle count N>1. The counter `cnt` is loaded with N−1.
  - In MD_WAIT, `cnt` decrements each cycle while `stall_i`=0.
  - MD_WAIT → RUN in the cycle after the cycle in which `cnt`==0.
- **Outputs during MD_WAIT.** `stall_o`=1 except when `cnt`==0. `rf_en_o` is gated to 0 except when `cnt`==0.
- **`md_start_o`.** Asserts in the first cycle the M-op bundle is live, for any N.
- **Stall.** `stall_i`=1 freezes the bundle, FSM and counter.
- **Flush.** `flush_i` clears the bundle to a bubble and returns the FSM to RUN with `cnt`=0. Flush has priority over stall and over accept.
- **Reset.** Same effect as flush. All outputs go to 0, except `br_type_o`=110.

## Timing
- Decode latency is one cycle: an instruction accepted at edge N is visible on the outputs after edge N.
- An N-cycle M op occupies the execute stage for exactly N cycles when `stall_i`=0. `rf_en_o` is high only in the last of those cycles.
- The next instruction is accepted in that last cycle and appears in the following cycle.
- `stall_o` is combinational from state and `cnt`. It never depends on `instr_i` in the same cycle.
- With `flush_i` and `stall_i` both high, the flush takes effect.
- A flush arriving in the last MD_WAIT cycle cancels the writeback: `rf_en_o` is 0 in that cycle.

## Structure
- Package `ctrl_pkg` holds:
  - opcode constants;
  - enums for `aluop_e`, `br_type_e`, `mem_type_e`, `sel_wb_e`, `imm_type_e` and `csr_op_e`;
  - the packed struct `ctrl_bundle_t`.
- Sub-module `rv_ctrl_decode` is purely combinational: `instr_i` + `ENABLE_M` → `ctrl_bundle_t` + `is_md` + cycle count.
- The top level holds the bundle register, the FSM and the counter.

## Test plan
- ADD (0x00B50533) at cycle 0 → cycle 1: `rf_en_o`=1, `aluop_o`=0x00, `sel_wb_o`=00, `stall_o`=0.
- DIV (0x02B54533) with `DIV_CYCLES`=4 → `md_start_o` in cycle 1 only; `stall_o`=1 in cycles 1–3; `rf_en_o`=1 only in cycle 4; next instruction live in cycle 5.
- The same DIV with `flush_i` in cycle 2 → cycle 3 is a bubble, the FSM is in RUN, `rf_en_o` is never set, `stall_o`=0.
- `ENABLE_M`=0 with MUL → `illegal_o`=1 and all enables 0. Opcode 0x7F → `illegal_o`=1.
- CSRRS x5, mstatus, x0 → `csr_rd_o`=1, `csr_wr_o`=0. Encoding 0x30200073 → `is_mret_o`=1.
- `stall_i` held for 3 cycles during a DIV → completion is delayed by exactly 3 cycles. Reset mid-DIV → all outputs 0 and the FSM in RUN.
